// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 32 integer register file.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  // Architectural x0: reads as zero, writes are dropped.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One synchronous read port: select mux, x0 masking, optional write-first
// forwarding and the registered output.
// Optional feature: REGFILE_WRITE_BYPASS_EN forwards same-edge write data.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rsel,
  input  logic [DW-1:0] regs [2**AW],
  input  logic          wen,
  input  logic [AW-1:0] wsel,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] rdata_reg;
  logic [DW-1:0] rdata_next;

  // Select the addressed entry; x0 is forced to zero regardless of storage.
  always_comb begin
    rdata_next = regs[rsel];
    if (rsel == AW'(ZERO_REG)) begin
      rdata_next = '0;
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wen && (wsel != AW'(ZERO_REG)) && (rsel == wsel)) begin
      rdata_next = wdata;
    end
`endif
  end

`ifndef REGFILE_WRITE_BYPASS_EN
  // Write-port inputs only matter when forwarding is built in.
  logic unused_bypass;
  assign unused_bypass = ^{wen, wsel, wdata};
`endif

  // Output register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg <= '0;
    end else begin
      rdata_reg <= rdata_next;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/register_file.sv
// 32-entry x 32-bit RISC-V integer register file, 2 read / 1 write port.
// Reads are registered (1-cycle latency); x0 is hardwired to zero.
// Optional feature: REGFILE_WRITE_BYPASS_EN selects write-first forwarding
// on same-edge read/write of one entry; default is read-before-write.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rsel1,
  input  logic [ADDR_WIDTH-1:0] rsel2,
  input  logic [ADDR_WIDTH-1:0] wsel,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wen,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]  regs_reg [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] we_dec;

  // One-hot write decode; entry 0 never gets an enable.
  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_wdec
      if (gi == ZERO_REG) begin : g_x0
        assign we_dec[gi] = 1'b0;
      end else begin : g_xn
        assign we_dec[gi] = wen && (wsel == ADDR_WIDTH'(gi));
      end
    end
  endgenerate

  // Storage array; reset clears every entry, reset also blocks writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (we_dec[i]) begin
          regs_reg[i] <= wdata;
        end
      end
    end
  end

  regfile_read_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_rport1 (
    .clk   (clk),
    .rst   (rst),
    .rsel  (rsel1),
    .regs  (regs_reg),
    .wen   (wen),
    .wsel  (wsel),
    .wdata (wdata),
    .rdata (rdata1)
  );

  regfile_read_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_rport2 (
    .clk   (clk),
    .rst   (rst),
    .rsel  (rsel2),
    .regs  (regs_reg),
    .wen   (wen),
    .wsel  (wsel),
    .wdata (wdata),
    .rdata (rdata2)
  );

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rsel1;
  logic [4:0]  rsel2;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic        wen;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int vectors = 0;
  int errors  = 0;
  int txn     = 0;

  // Reference model: plain architectural register contents.
  logic [31:0] mem [32];

  register_file dut (
    .clk    (clk),
    .rst    (rst),
    .rsel1  (rsel1),
    .rsel2  (rsel2),
    .wsel   (wsel),
    .wdata  (wdata),
    .wen    (wen),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Value a read of entry r returns on an edge carrying write (w, ws, wd).
  function automatic logic [31:0] model_read(input logic [4:0] r, input logic w,
                                             input logic [4:0] ws, input logic [31:0] wd);
    if (r == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (w && ws != 5'd0 && ws == r) return wd;
`endif
    return mem[r];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  // Apply one transaction across one rising edge and check both ports.
  task automatic step(input logic w, input logic [4:0] ws, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input string tag);
    logic [31:0] e1, e2;
    @(negedge clk);
    wen = w; wsel = ws; wdata = wd; rsel1 = r1; rsel2 = r2;
    @(posedge clk);
    e1 = model_read(r1, w, ws, wd);
    e2 = model_read(r2, w, ws, wd);
    if (w && ws != 5'd0) mem[ws] = wd;
    #1;
    txn++;
    $display("txn %0d %s wen=%0b wsel=%0d wdata=%08h rsel1=%0d rsel2=%0d rdata1=%08h rdata2=%08h",
             txn, tag, w, ws, wd, r1, r2, rdata1, rdata2);
    check({tag, "_p1"}, rdata1, e1);
    check({tag, "_p2"}, rdata2, e2);
  endtask

  initial begin
    logic [4:0]  ws;
    logic [31:0] wd;

    rst = 1'b0; wen = 1'b0; wsel = '0; wdata = '0; rsel1 = '0; rsel2 = '0;
    model_clear();

    // Reset held for two edges, with a write attempt that must be ignored.
    @(negedge clk);
    wen = 1'b1; wsel = 5'd5; wdata = 32'h5555_AAAA; rsel1 = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd1", rdata1, 32'h0);
    check("reset_rd2", rdata2, 32'h0);
    @(negedge clk);
    wen = 1'b0;
    rst = 1'b1;

    // Post-reset sweep: every entry reads zero on both ports.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'((i + 1) % 32), "rst_sweep");
      check("rst_sweep_const", rdata1 | rdata2, 32'h0);
    end

    // Simple write then read.
    step(1'b1, 5'd10, 32'hABCD_1234, 5'd0, 5'd0, "wr10");
    step(1'b0, 5'd0, 32'h0, 5'd10, 5'd10, "rd10");
    check("rd10_const", rdata1, 32'hABCD_1234);

    // Disabled write leaves r11 untouched.
    step(1'b0, 5'd11, 32'hDEAD_BEEF, 5'd0, 5'd0, "nowr11");
    step(1'b0, 5'd0, 32'h0, 5'd11, 5'd10, "rd11");
    check("rd11_const", rdata1, 32'h0);

    // Same-edge read/write of r12.
    step(1'b1, 5'd12, 32'hAAAA_5555, 5'd0, 5'd0, "wr12");
    step(1'b1, 5'd12, 32'hFFFF_0000, 5'd12, 5'd12, "rw12");
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rw12_const", rdata1, 32'hFFFF_0000);
`else
    check("rw12_const", rdata1, 32'hAAAA_5555);
`endif
    step(1'b0, 5'd0, 32'h0, 5'd12, 5'd0, "rd12");
    check("rd12_const", rdata1, 32'hFFFF_0000);

    // Boundaries: x0 discards writes, x31 is a normal entry.
    step(1'b1, 5'd0, 32'hDECA_FBAD, 5'd0, 5'd0, "wr0");
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd31, "rd0");
    check("rd0_const", rdata1, 32'h0);
    step(1'b1, 5'd31, 32'h1234_5678, 5'd0, 5'd0, "wr31");
    step(1'b0, 5'd0, 32'h0, 5'd31, 5'd0, "rd31");
    check("rd31_const", rdata1, 32'h1234_5678);

    // Ten random write-then-read pairs.
    for (int i = 0; i < 10; i++) begin
      ws = 5'($urandom_range(0, 31));
      wd = $urandom;
      step(1'b1, ws, wd, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rnd_wr");
      step(1'b0, 5'd0, 32'h0, ws, ws, "rnd_rd");
      check("rnd_rd_const", rdata2, (ws == 5'd0) ? 32'h0 : wd);
    end

    // Fully random traffic, including collisions between ports and writes.
    for (int i = 0; i < 300; i++) begin
      ws = 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), ws, $urandom,
           ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 31)), "rnd");
    end

    // Make outputs non-zero, then assert reset between edges.
    step(1'b1, 5'd7, 32'hCAFE_0007, 5'd0, 5'd0, "wr7");
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd31, "rd7");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_rd1", rdata1, 32'h0);
    check("midrst_rd2", rdata2, 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    check("midrst_hold1", rdata1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "post_rst");
      check("post_rst_const", rdata1 | rdata2, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit integer register file for the RISC-V core; two read ports and one write port.
- x0 is hardwired to zero.
- Reads are synchronous: each read port's output register captures the addressed entry on the rising clock edge.
- Sits between decode (read selects) and writeback (write port).

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, width of the select ports; entry count = 2**ADDR_WIDTH (32).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronized externally.
- rsel1  in  ADDR_WIDTH  read port 1 select.
- rsel2  in  ADDR_WIDTH  read port 2 select.
- wsel  in  ADDR_WIDTH  write select.
- wdata  in  DATA_WIDTH  write data.
- wen  in  1  write enable, active-high.
- rdata1  out  DATA_WIDTH  registered read data, port 1.
- rdata2  out  DATA_WIDTH  registered read data, port 2.

Behaviour:
- Reset (rst=0, asynchronous):
  - all 32 entries clear to 0;
  - rdata1 and rdata2 clear to 0;
  - writes are ignored while reset is asserted.
- Write: on a rising edge with wen=1 and wsel!=0, entry[wsel] <= wdata.
  - wen=0: no entry changes, regardless of wsel/wdata.
  - wsel=0: write discarded; entry 0 always reads 0.
- Read: on every rising edge, rdataN <= entry[rselN] (0 when rselN=0).
  - Latency: 1 cycle from select change to data valid.
  - Output holds between edges.
- Read/write to the same entry on the same edge (macro undefined):
  - read port returns the OLD value;
  - the new value is visible on the following edge's read.
- Both read ports are independent; they may select the same entry or the write target at the same time.
- No X propagation: every select value 0..31 is legal, including 31.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: when wen=1, wsel!=0 and rselN==wsel on the same edge, rdataN captures wdata (new value, write-first forwarding). This applies per port; wsel=0 is never forwarded.
- Undefined (default): read-before-write behaviour as specified above.

Decomposition:
- Package regfile_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS constants;
  - typedefs reg_addr_t and reg_data_t;
  - constant ZERO_REG = 0.
- One sub-module, regfile_read_port, instantiated twice. It contains:
  - the select mux;
  - x0 masking;
  - the optional bypass compare;
  - the async-reset output register.
- Storage array and write decode stay in register_file.

Test Plan:
- Reset: assert rst=0 for 2 cycles, release; sweep rsel1=i, rsel2=(i+1)%32 for i=0..31 -> rdata1 = rdata2 = 0x00000000 every cycle.
- Simple write/read: wen=1, wsel=10, wdata=0xABCD1234 for one edge; then rsel1=10 -> rdata1 = 0xABCD1234 after the next edge.
- Disabled write: wen=0, wsel=11, wdata=0xDEADBEEF; then read r11 -> 0x00000000.
- Same-edge read/write (macro undefined):
  - write r12 = 0xAAAA5555;
  - next edge: wen=1, wsel=12, wdata=0xFFFF0000, rsel1=12 -> rdata1 = 0xAAAA5555;
  - following edge -> rdata1 = 0xFFFF0000.
  - With REGFILE_WRITE_BYPASS_EN defined, the first read returns 0xFFFF0000.
- Boundaries:
  - write r0 = 0xDECAFBAD, read r0 -> 0x00000000;
  - write r31 = 0x12345678, read r31 -> 0x12345678.
- Random plus mid-operation reset:
  - 10 random (wsel, wdata) write-then-read pairs -> readback equals wdata (0 for wsel=0);
  - assert rst mid-sequence -> outputs go to 0 immediately, and all entries read 0 afterwards.
